// File: rtl/tx_framer.sv
// Transmit framer: buffers a fixed-length payload with a running XOR checksum,
// then serializes preamble, sync, payload and checksum MSB-first on bit_en strobes.
module tx_framer #(
  parameter logic [7:0] PREAMBLE       = 8'hAA,
  parameter int         PREAMBLE_BYTES = 2,
  parameter logic [7:0] SYNC           = 8'hD3,
  parameter int         PAYLOAD_BYTES  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  input  logic       start,
  input  logic       abort,
  input  logic       bit_en,
  output logic       dout,
  output logic       busy,
  output logic       done
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_FILL     = 3'd1;
  localparam logic [2:0] S_READY    = 3'd2;
  localparam logic [2:0] S_PREAMBLE = 3'd3;
  localparam logic [2:0] S_SYNC     = 3'd4;
  localparam logic [2:0] S_PAYLOAD  = 3'd5;
  localparam logic [2:0] S_CHECK    = 3'd6;
  localparam logic [2:0] S_END      = 3'd7;

  localparam logic [3:0] LAST_PAY = 4'(PAYLOAD_BYTES - 1);
  localparam logic [3:0] LAST_PRE = 4'(PREAMBLE_BYTES - 1);

  logic [2:0] state;
  logic [3:0] wr_cnt;
  logic [7:0] csum;
  logic [7:0] shreg;
  logic [2:0] bit_cnt;
  logic [3:0] byte_idx;
  logic [7:0] mem [16];
  logic       accept;

  assign din_ready = (state == S_IDLE) || (state == S_FILL);
  assign accept    = din_valid && din_ready && !abort;

  // Payload storage carries no reset; contents are only read after a full fill.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_cnt] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      wr_cnt   <= '0;
      csum     <= '0;
      shreg    <= '0;
      bit_cnt  <= '0;
      byte_idx <= '0;
      dout     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state  <= S_IDLE;
        wr_cnt <= '0;
        csum   <= '0;
        dout   <= 1'b0;
        busy   <= 1'b0;
      end else begin
        case (state)
          S_IDLE, S_FILL: begin
            if (din_valid) begin
              wr_cnt <= wr_cnt + 4'd1;
              csum   <= csum ^ din;
              state  <= (wr_cnt == LAST_PAY) ? S_READY : S_FILL;
            end
          end
          S_READY: begin
            if (start) begin
              busy     <= 1'b1;
              state    <= S_PREAMBLE;
              shreg    <= PREAMBLE;
              bit_cnt  <= '0;
              byte_idx <= '0;
            end
          end
          S_PREAMBLE, S_SYNC, S_PAYLOAD, S_CHECK: begin
            if (bit_en) begin
              dout    <= shreg[7];
              shreg   <= {shreg[6:0], 1'b0};
              bit_cnt <= bit_cnt + 3'd1;
              // Byte boundary: load the next byte and advance the state together.
              if (bit_cnt == 3'd7) begin
                case (state)
                  S_PREAMBLE: begin
                    if (byte_idx == LAST_PRE) begin
                      shreg    <= SYNC;
                      state    <= S_SYNC;
                      byte_idx <= '0;
                    end else begin
                      shreg    <= PREAMBLE;
                      byte_idx <= byte_idx + 4'd1;
                    end
                  end
                  S_SYNC: begin
                    shreg    <= mem[4'd0];
                    state    <= S_PAYLOAD;
                    byte_idx <= '0;
                  end
                  S_PAYLOAD: begin
                    if (byte_idx == LAST_PAY) begin
                      shreg <= csum;
                      state <= S_CHECK;
                    end else begin
                      shreg    <= mem[byte_idx + 4'd1];
                      byte_idx <= byte_idx + 4'd1;
                    end
                  end
                  default: state <= S_END;
                endcase
              end
            end
          end
          S_END: begin
            if (bit_en) begin
              dout   <= 1'b0;
              busy   <= 1'b0;
              done   <= 1'b1;
              wr_cnt <= '0;
              csum   <= '0;
              state  <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tx_framer.sv
// Randomized bench for tx_framer: expected frames are built byte-wise from the
// payload and expanded to an MSB-first bit queue.
module tb_tx_framer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic       din_valid, start, abort, bit_en;
  logic       din_ready, dout, busy, done;

  logic [7:0] s_din;
  logic       s_din_valid, s_start, s_abort, s_bit_en;
  logic       s_din_ready, s_dout, s_busy, s_done;

  int         n_checks = 0;
  int         n_fail   = 0;
  bit         exp_bits[$];
  logic [7:0] pay_q[$];
  logic       last_bit;

  always #5 clk = ~clk;

  tx_framer u_dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .start(start), .abort(abort), .bit_en(bit_en), .dout(dout), .busy(busy), .done(done)
  );

  tx_framer #(.PREAMBLE_BYTES(1), .PAYLOAD_BYTES(1)) u_small (
    .clk(clk), .rst(rst), .din(s_din), .din_valid(s_din_valid), .din_ready(s_din_ready),
    .start(s_start), .abort(s_abort), .bit_en(s_bit_en), .dout(s_dout), .busy(s_busy),
    .done(s_done)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference frame: preamble bytes, sync, payload, XOR of payload.
  function automatic void build_frame(input int npre);
    logic [7:0] bytes[$];
    logic [7:0] x;
    x = 8'h00;
    repeat (npre) bytes.push_back(8'hAA);
    bytes.push_back(8'hD3);
    foreach (pay_q[i]) begin
      bytes.push_back(pay_q[i]);
      x ^= pay_q[i];
    end
    bytes.push_back(x);
    exp_bits.delete();
    foreach (bytes[i])
      for (int b = 7; b >= 0; b--) exp_bits.push_back(bytes[i][b]);
    last_bit = 1'b0;
  endfunction

  task automatic push(input logic [7:0] b);
    din = b;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
  endtask

  task automatic fill_random();
    pay_q.delete();
    for (int i = 0; i < 8; i++) begin
      pay_q.push_back(8'($urandom));
      push(pay_q[i]);
      repeat ($urandom_range(2, 0)) tick();
    end
  endtask

  task automatic run_bits(input int n, input int gmin, input int gmax);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(gmax, gmin)) begin
        tick();
        check_val("dout_hold", dout, last_bit);
      end
      bit_en = 1'b1;
      tick();
      bit_en = 1'b0;
      last_bit = exp_bits.pop_front();
      check_val("dout_bit", dout, last_bit);
      check_val("busy_tx", busy, 1);
      check_val("done_early", done, 0);
    end
  endtask

  task automatic finish_frame();
    check_val("bits_left", exp_bits.size(), 0);
    tick();
    check_val("end_hold", dout, last_bit);
    bit_en = 1'b1;
    tick();
    bit_en = 1'b0;
    check_val("done_pulse", done, 1);
    check_val("busy_end", busy, 0);
    check_val("dout_end", dout, 0);
    tick();
    check_val("done_clear", done, 0);
    check_val("ready_after", din_ready, 1);
  endtask

  initial begin
    rst = 1'b1;
    din = 8'h00; din_valid = 1'b0; start = 1'b0; abort = 1'b0; bit_en = 1'b0;
    s_din = 8'h00; s_din_valid = 1'b0; s_start = 1'b0; s_abort = 1'b0; s_bit_en = 1'b0;
    repeat (3) tick();
    check_val("rst_dout", dout, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_ready", din_ready, 1);
    check_val("rst_s_ready", s_din_ready, 1);
    rst = 1'b0;
    tick();

    // Frame of 01..08 with an early start, an overflow byte, strobe every 4 clk.
    pay_q.delete();
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check_val("early_start_busy", busy, 0);
        check_val("early_start_ready", din_ready, 1);
      end
      pay_q.push_back(8'(i + 1));
      push(8'(i + 1));
    end
    check_val("full_ready", din_ready, 0);
    push(8'hFF);
    check_val("overflow_ready", din_ready, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_val("start_busy", busy, 1);
    check_val("start_dout", dout, 0);
    build_frame(2);
    run_bits(96, 3, 3);
    finish_frame();

    // Random payload; start with coincident bit_en and din_valid, irregular strobes.
    fill_random();
    start = 1'b1; bit_en = 1'b1; din = 8'hEE; din_valid = 1'b1;
    tick();
    start = 1'b0; bit_en = 1'b0; din_valid = 1'b0;
    check_val("co_start_busy", busy, 1);
    check_val("co_start_dout", dout, 0);
    check_val("co_start_ready", din_ready, 0);
    build_frame(2);
    run_bits(96, 0, 19);
    finish_frame();

    // Abort in SYNC together with start and bit_en, then refill 10,20 x4.
    fill_random();
    start = 1'b1;
    tick();
    start = 1'b0;
    build_frame(2);
    run_bits(19, 0, 5);
    abort = 1'b1; bit_en = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; bit_en = 1'b0; start = 1'b0;
    check_val("abort_busy", busy, 0);
    check_val("abort_dout", dout, 0);
    check_val("abort_ready", din_ready, 1);
    check_val("abort_done", done, 0);
    tick();
    check_val("abort_done2", done, 0);
    check_val("abort_busy2", busy, 0);
    pay_q.delete();
    for (int i = 0; i < 4; i++) begin
      pay_q.push_back(8'h10); push(8'h10);
      pay_q.push_back(8'h20); push(8'h20);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    build_frame(2);
    run_bits(96, 0, 7);
    finish_frame();

    // Asynchronous reset in the middle of the payload.
    fill_random();
    start = 1'b1;
    tick();
    start = 1'b0;
    build_frame(2);
    run_bits(34, 0, 3);
    #2 rst = 1'b1;
    #1;
    check_val("mid_rst_dout", dout, 0);
    check_val("mid_rst_busy", busy, 0);
    check_val("mid_rst_ready", din_ready, 1);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bit_en = 1'b1;
      tick();
      bit_en = 1'b0;
      check_val("post_rst_done", done, 0);
      check_val("post_rst_busy", busy, 0);
    end

    // Single-byte payload, single preamble: IDLE straight to READY.
    s_din = 8'h5A; s_din_valid = 1'b1;
    tick();
    s_din_valid = 1'b0;
    check_val("s_ready_full", s_din_ready, 0);
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    check_val("s_busy", s_busy, 1);
    pay_q.delete();
    pay_q.push_back(8'h5A);
    build_frame(1);
    check_val("s_frame_len", exp_bits.size(), 32);
    for (int i = 0; i < 32; i++) begin
      repeat (2) tick();
      s_bit_en = 1'b1;
      tick();
      s_bit_en = 1'b0;
      check_val("s_dout_bit", s_dout, exp_bits.pop_front());
      check_val("s_done_early", s_done, 0);
    end
    tick();
    s_bit_en = 1'b1;
    tick();
    s_bit_en = 1'b0;
    check_val("s_done_pulse", s_done, 1);
    check_val("s_busy_end", s_busy, 0);
    check_val("s_ready_after", s_din_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1);
  end

endmodule
